// File: rtl/mem_reader_ctrl.sv
// Memory-reader controller: streams filter words then packed image words from a
// one-cycle-latency memory into the filter/image buffers, with back-pressure.
module mem_reader_ctrl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned FILTER_WORDS = 4,
    parameter int unsigned IMG_SIZE     = 16,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned FILTER_BASE  = 0,
    parameter int unsigned IMG_BASE     = 64,
    localparam int unsigned IMG_WORDS   = IMG_SIZE * IMG_SIZE / PIX_PER_WORD,
    localparam int unsigned SEL_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int unsigned WORD_W      = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1,
    localparam int unsigned IMG_W       = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              img_only_i,
    input  logic              buf_ready_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              filter_wr_en_o,
    output logic [SEL_W-1:0]  filter_sel_o,
    output logic [WORD_W-1:0] filter_word_o,
    output logic              img_wr_en_o,
    output logic [IMG_W-1:0]  img_word_o,
    output logic              busy_o,
    output logic              done_o
);

    if (((IMG_SIZE * IMG_SIZE) % PIX_PER_WORD) != 0) begin : gen_geom_err
        $error("IMG_SIZE*IMG_SIZE must be divisible by PIX_PER_WORD");
    end
    if (NUM_FILTERS < 1 || FILTER_WORDS < 1) begin : gen_filt_err
        $error("NUM_FILTERS and FILTER_WORDS must be at least 1");
    end

    localparam logic [ADDR_W-1:0] FilterBaseA  = ADDR_W'(FILTER_BASE);
    localparam logic [ADDR_W-1:0] ImgBaseA     = ADDR_W'(IMG_BASE);
    localparam logic [ADDR_W-1:0] FilterWordsA = ADDR_W'(FILTER_WORDS);
    localparam logic [SEL_W-1:0]  LastSel      = SEL_W'(NUM_FILTERS - 1);
    localparam logic [WORD_W-1:0] LastWord     = WORD_W'(FILTER_WORDS - 1);
    localparam logic [IMG_W-1:0]  LastImg      = IMG_W'(IMG_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StLdFilter, StLdImg, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  f_q, f_d;
    logic [WORD_W-1:0] w_q, w_d;
    logic [IMG_W-1:0]  i_q, i_d;
    logic              filter_wr_en_q, img_wr_en_q;
    logic [SEL_W-1:0]  filter_sel_q;
    logic [WORD_W-1:0] filter_word_q;
    logic [IMG_W-1:0]  img_word_q;
    logic              issue;
    logic              last_filter, last_img;
    logic [ADDR_W-1:0] filt_addr, img_addr;

    assign last_filter = (f_q == LastSel) && (w_q == LastWord);
    assign last_img    = (i_q == LastImg);
    assign filt_addr   = FilterBaseA + ADDR_W'(f_q) * FilterWordsA + ADDR_W'(w_q);
    assign img_addr    = ImgBaseA + ADDR_W'(i_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_i) state_d = img_only_i ? StLdImg : StLdFilter;
            StLdFilter: if (issue && last_filter) state_d = StLdImg;
            StLdImg:    if (issue && last_img) state_d = StDrain;
            StDrain:    state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        issue       = ((state_q == StLdFilter) || (state_q == StLdImg)) && buf_ready_i;
        mem_rd_en_o = issue;
        mem_addr_o  = '0;
        if (issue) begin
            mem_addr_o = (state_q == StLdFilter) ? filt_addr : img_addr;
        end
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    // Counters move only on an issued read; the word counter carries into the filter counter.
    always_comb begin
        f_d = f_q;
        w_d = w_q;
        i_d = i_q;
        if (state_d == StIdle) begin
            f_d = '0;
            w_d = '0;
            i_d = '0;
        end else if (issue && state_q == StLdFilter) begin
            if (last_filter) begin
                f_d = '0;
                w_d = '0;
            end else if (w_q == LastWord) begin
                w_d = '0;
                f_d = f_q + 1'b1;
            end else begin
                w_d = w_q + 1'b1;
            end
        end else if (issue) begin
            i_d = last_img ? '0 : i_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_q            <= '0;
            w_q            <= '0;
            i_q            <= '0;
            filter_wr_en_q <= 1'b0;
            img_wr_en_q    <= 1'b0;
            filter_sel_q   <= '0;
            filter_word_q  <= '0;
            img_word_q     <= '0;
        end else begin
            f_q            <= f_d;
            w_q            <= w_d;
            i_q            <= i_d;
            filter_wr_en_q <= issue && (state_q == StLdFilter);
            img_wr_en_q    <= issue && (state_q == StLdImg);
            if (issue && state_q == StLdFilter) begin
                filter_sel_q  <= f_q;
                filter_word_q <= w_q;
            end
            if (issue && state_q == StLdImg) begin
                img_word_q <= i_q;
            end
        end
    end

    assign filter_wr_en_o = filter_wr_en_q;
    assign filter_sel_o   = filter_sel_q;
    assign filter_word_o  = filter_word_q;
    assign img_wr_en_o    = img_wr_en_q;
    assign img_word_o     = img_word_q;

endmodule

// File: tb/tb_mem_reader_ctrl.sv
// Directed bench for mem_reader_ctrl: default geometry runs from a vector table plus
// reset, late-start and small-geometry address-wrap sequences.
module tb_mem_reader_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, img_only, buf_ready;
    logic        rd_en, fwe, iwe, busy, done;
    logic [15:0] addr;
    logic [1:0]  fsel, fword;
    logic [5:0]  iword;

    logic        s_rst, s_start, s_img_only, s_buf_ready;
    logic        s_rd_en, s_fwe, s_iwe, s_busy, s_done;
    logic [15:0] s_addr;
    logic [0:0]  s_fsel;
    logic [1:0]  s_fword;
    logic [2:0]  s_iword;

    mem_reader_ctrl u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .img_only_i    (img_only),
        .buf_ready_i   (buf_ready),
        .mem_rd_en_o   (rd_en),
        .mem_addr_o    (addr),
        .filter_wr_en_o(fwe),
        .filter_sel_o  (fsel),
        .filter_word_o (fword),
        .img_wr_en_o   (iwe),
        .img_word_o    (iword),
        .busy_o        (busy),
        .done_o        (done)
    );

    mem_reader_ctrl #(
        .NUM_FILTERS (2),
        .FILTER_WORDS(3),
        .IMG_SIZE    (4),
        .PIX_PER_WORD(2),
        .IMG_BASE    (32'hFFFE)
    ) u_small (
        .clk_i         (clk),
        .rst_i         (s_rst),
        .start_i       (s_start),
        .img_only_i    (s_img_only),
        .buf_ready_i   (s_buf_ready),
        .mem_rd_en_o   (s_rd_en),
        .mem_addr_o    (s_addr),
        .filter_wr_en_o(s_fwe),
        .filter_sel_o  (s_fsel),
        .filter_word_o (s_fword),
        .img_wr_en_o   (s_iwe),
        .img_word_o    (s_iword),
        .busy_o        (s_busy),
        .done_o        (s_done)
    );

    typedef struct {
        logic img_only;
        int   stall_lo;
        int   stall_hi;
        int   pulse;
        int   exp_reads;
        int   exp_done;
    } run_t;

    run_t runs[5];
    int checks = 0;
    int passes = 0;
    logic [15:0] s_exp [14] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                                16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                16'h0004, 16'h0005};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " rd_en"}, 32'(rd_en), 0);
        chk({tag, " addr"}, 32'(addr), 0);
        chk({tag, " filter_wr_en"}, 32'(fwe), 0);
        chk({tag, " filter_sel"}, 32'(fsel), 0);
        chk({tag, " filter_word"}, 32'(fword), 0);
        chk({tag, " img_wr_en"}, 32'(iwe), 0);
        chk({tag, " img_word"}, 32'(iword), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
    endtask

    // Call just after a rising edge; that next edge is cycle 0.
    task automatic run_load(input run_t r, input int id);
        int   rd_idx, fw_idx, iw_idx, n_filt;
        logic prev_rd;
        logic [31:0] ea;
        n_filt  = r.img_only ? 0 : 16;
        rd_idx  = 0;
        fw_idx  = 0;
        iw_idx  = 0;
        prev_rd = 1'b0;
        start = 1'b1;
        img_only = r.img_only;
        buf_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        img_only = 1'b0;
        for (int k = 1; k <= r.exp_done + 1; k++) begin
            buf_ready = !(k >= r.stall_lo && k <= r.stall_hi);
            start     = (k == r.pulse);
            img_only  = (k == r.pulse);
            @(negedge clk);
            if (!buf_ready) chk($sformatf("run%0d stalled rd_en@%0d", id, k), 32'(rd_en), 0);
            if (rd_en) begin
                ea = (rd_idx < n_filt) ? 32'(rd_idx) : 32'(64 + rd_idx - n_filt);
                chk($sformatf("run%0d addr@%0d", id, k), 32'(addr), ea);
                rd_idx++;
            end
            chk($sformatf("run%0d wr_count@%0d", id, k), 32'(fwe) + 32'(iwe), 32'(prev_rd));
            if (fwe) begin
                chk($sformatf("run%0d filter_sel@%0d", id, k), 32'(fsel), 32'(fw_idx / 4));
                chk($sformatf("run%0d filter_word@%0d", id, k), 32'(fword), 32'(fw_idx % 4));
                fw_idx++;
            end
            if (iwe) begin
                chk($sformatf("run%0d img_word@%0d", id, k), 32'(iword), 32'(iw_idx));
                iw_idx++;
            end
            chk($sformatf("run%0d busy@%0d", id, k), 32'(busy), 32'(k <= r.exp_done));
            chk($sformatf("run%0d done@%0d", id, k), 32'(done), 32'(k == r.exp_done));
            prev_rd = rd_en;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        img_only = 1'b0;
        buf_ready = 1'b1;
        chk($sformatf("run%0d read count", id), 32'(rd_idx), 32'(r.exp_reads));
        chk($sformatf("run%0d filter writes", id), 32'(fw_idx), 32'(n_filt));
        chk($sformatf("run%0d image writes", id), 32'(iw_idx), 64);
    endtask

    initial begin
        int rd_idx, fw_idx, iw_idx;
        runs[0] = '{1'b0, 0, 0, 0, 80, 82};
        runs[1] = '{1'b1, 0, 0, 0, 64, 66};
        runs[2] = '{1'b0, 5, 7, 0, 80, 85};
        runs[3] = '{1'b0, 0, 0, 40, 80, 82};
        runs[4] = '{1'b1, 10, 11, 0, 64, 68};

        rst = 1'b1; start = 1'b0; img_only = 1'b0; buf_ready = 1'b1;
        s_rst = 1'b1; s_start = 1'b0; s_img_only = 1'b0; s_buf_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_rst = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 5; r++) begin
            run_load(runs[r], r);
            @(posedge clk);
            #1;
        end

        // Reset mid-load: the read issued in cycle 30 must never be written.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            rst = (k == 30);
            @(negedge clk);
            if (k == 30) chk("rst cycle30 rd_en", 32'(rd_en), 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("after rst");
        @(posedge clk);
        #1;
        run_load(runs[0], 5);

        // Small geometry with image addresses wrapping through 0.
        rd_idx = 0;
        fw_idx = 0;
        iw_idx = 0;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (s_rd_en) begin
                if (rd_idx < 14) chk($sformatf("small addr@%0d", k), 32'(s_addr), 32'(s_exp[rd_idx]));
                rd_idx++;
            end
            if (s_fwe) begin
                chk($sformatf("small filter_sel@%0d", k), 32'(s_fsel), 32'(fw_idx / 3));
                chk($sformatf("small filter_word@%0d", k), 32'(s_fword), 32'(fw_idx % 3));
                fw_idx++;
            end
            if (s_iwe) begin
                chk($sformatf("small img_word@%0d", k), 32'(s_iword), 32'(iw_idx));
                iw_idx++;
            end
            chk($sformatf("small busy@%0d", k), 32'(s_busy), 32'(k <= 16));
            chk($sformatf("small done@%0d", k), 32'(s_done), 32'(k == 16));
            @(posedge clk);
            #1;
        end
        chk("small read count", 32'(rd_idx), 14);
        chk("small filter writes", 32'(fw_idx), 6);
        chk("small image writes", 32'(iw_idx), 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_reader_ctrl.md
# mem_reader_ctrl

Parametrised memory-reader controller for the convolution accelerator. On `start`, it streams NUM_FILTERS filters of FILTER_WORDS words each, then one IMG_SIZE×IMG_SIZE image packed PIX_PER_WORD pixels per word, from a one-cycle-latency memory into the filter and image buffers. It extends the fixed 4-filter loader with three additions: parametrised geometry and base addresses, an image-only reload mode, and buffer back-pressure. It sits between the main controller and the memory/buffer datapath.

## Interface
- ADDR_W, 16, memory address width
- NUM_FILTERS, 4, filters per load (≥1)
- FILTER_WORDS, 4, memory words per filter (≥1)
- IMG_SIZE, 16, image side in pixels
- PIX_PER_WORD, 4, pixels per memory word; IMG_SIZE*IMG_SIZE must be divisible by it (elaboration error otherwise)
- FILTER_BASE, 0, address of filter 0 word 0
- IMG_BASE, 64, address of image word 0
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- img_only  in  1  sampled with start; 1 = skip filters, load image only
- buf_ready  in  1  buffers can accept; 0 stalls read issue
- mem_rd_en  out  1  memory read request this cycle
- mem_addr  out  ADDR_W  read address, valid when mem_rd_en=1
- filter_wr_en  out  1  write returned word into filter buffer
- filter_sel  out  clog2(NUM_FILTERS) (min 1)  target filter, valid with filter_wr_en
- filter_word  out  clog2(FILTER_WORDS) (min 1)  word index in filter, valid with filter_wr_en
- img_wr_en  out  1  write returned word into image buffer
- img_word  out  clog2(IMG_WORDS) (min 1)  image word index, valid with img_wr_en
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at load completion

## Operation
- IMG_WORDS = IMG_SIZE*IMG_SIZE/PIX_PER_WORD.
- States:
  - IDLE: start=1 → LD_IMG if img_only=1, else LD_FILTER.
  - LD_FILTER: one read issued per cycle while buf_ready=1. Issuing the read for filter NUM_FILTERS-1, word FILTER_WORDS-1 → LD_IMG.
  - LD_IMG: one read issued per cycle while buf_ready=1. Issuing the read for word IMG_WORDS-1 → DRAIN.
  - DRAIN: no read issued; always → DONE.
  - DONE: done=1; always → IDLE.
- Issue condition: mem_rd_en = (LD_FILTER or LD_IMG) && buf_ready.
- Counters advance only on an issue:
  - word counter wraps FILTER_WORDS-1→0 and increments the filter counter.
  - all counters clear on entry to IDLE.
- Addresses:
  - filter: FILTER_BASE + f*FILTER_WORDS + w.
  - image: IMG_BASE + i.
  - Computed at ADDR_W bits, wrap modulo 2^ADDR_W.
- Write pipeline:
  - a read issued in cycle t produces exactly one write enable in cycle t+1, carrying the indices of the issued read.
  - buf_ready does not cancel a write already in flight.
- start while busy=1 is ignored. img_only is ignored except in the cycle start is accepted.
- rst=1 (any state, including mid-load): next cycle state=IDLE, counters=0, pending write dropped.

## Timing
- Reset values: all outputs 0, including mem_addr and all index outputs.
- mem_rd_en, mem_addr and busy are combinational from registered state/counters and buf_ready.
- Write enables and indices are registered (one-cycle delay after issue).
- Cycle numbering: cycle 0 is the edge that samples start.
  - Full load with buf_ready held at 1: reads in cycles 1..N, where N = NUM_FILTERS*FILTER_WORDS + IMG_WORDS.
  - Last write in cycle N+1 (DRAIN).
  - done in cycle N+2.
  - busy=1 in cycles 1..N+2.
- Each cycle with buf_ready=0 in LD_FILTER/LD_IMG delays done by exactly one cycle.
- At most one write enable is high in any cycle.
- Filter→image transition has no bubble: the last filter write and the first image read share a cycle.

## Test plan
- Defaults, img_only=0, buf_ready=1, one-cycle start at cycle 0 → 80 reads, addresses 0..15 then 64..127 in order; filter writes (sel,word) = (0,0)..(3,3); img_word 0..63; done high in cycle 82 only; busy cycles 1..82.
- img_only=1 with defaults → 64 reads, addresses 64..127; filter_wr_en never high; done in cycle 66.
- buf_ready=0 for cycles 5–7 during the filter load → no reads in those cycles; address sequence unchanged with no duplicates or skips; done in cycle 85.
- rst in cycle 30 → cycle 31: IDLE, all outputs 0, no write for the read issued in cycle 30. A new start then restarts from address 0.
- start pulsed in cycle 40 of an active load → ignored; exactly one done in cycle 82.
- NUM_FILTERS=2, FILTER_WORDS=3, IMG_SIZE=4, PIX_PER_WORD=2, IMG_BASE=16'hFFFE → filter addresses 0..5; image addresses FFFE, FFFF, 0000..0005; done in cycle 16.
